// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming KERNEL x KERNEL pooling engine (MAX or AVERAGE).
// Pixels arrive one per beat, all channels packed, in raster order. Each
// window is folded into a per-output-column accumulator as its beats go by.
// The pooled pixel is registered on the edge that accepts the beat that
// completes the window.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mode              0 = MAX, 1 = AVG; captured on the first beat of a frame
//   s_valid/s_ready   input stream handshake
//   s_data            CH signed Q(INT_W.FRAC_W) samples, ch at [ch*DW +: DW]
//   m_valid/m_ready   output stream handshake
//   m_data            pooled pixel, same packing as s_data
//   m_last            marks the final pooled pixel of a frame
module pool2d_stream #(
    parameter int CH     = 2,
    parameter int IN_H   = 8,
    parameter int IN_W   = 8,
    parameter int KERNEL = 2,
    parameter int STRIDE = 2,
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            mode,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [CH*(INT_W+FRAC_W)-1:0]    s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [CH*(INT_W+FRAC_W)-1:0]    m_data,
    output logic                            m_last
);
    localparam int DW    = INT_W + FRAC_W;
    localparam int KL    = $clog2(KERNEL);
    localparam int AW    = DW + 2*KL;
    localparam int OUT_H = (IN_H - KERNEL) / STRIDE + 1;
    localparam int OUT_W = (IN_W - KERNEL) / STRIDE + 1;
    localparam int RW    = $clog2(IN_H + 1);
    localparam int CW    = $clog2(IN_W + 1);
    localparam int PW    = $clog2(STRIDE + 1);

    // Overlapping windows would need more than one accumulator per column.
    if (STRIDE < KERNEL) begin : g_stride_chk
        $error("pool2d_stream: STRIDE must be >= KERNEL");
    end
    // The average is a pure shift, so the window area must be a power of two.
    if (KERNEL < 2 || (KERNEL & (KERNEL - 1)) != 0) begin : g_kernel_chk
        $error("pool2d_stream: KERNEL must be a power of two >= 2");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic               rdy_en_q;
    logic [RW-1:0]      r_q, r_d, oh_q, oh_d;
    logic [CW-1:0]      c_q, c_d, ow_q, ow_d;
    logic [PW-1:0]      rp_q, rp_d, cp_q, cp_d;
    logic               m_valid_q, m_valid_d;
    logic [CH*DW-1:0]   m_data_q, m_data_d;
    logic               m_last_q, m_last_d;

    logic signed [AW-1:0] acc_q   [OUT_W][CH];
    logic signed [AW-1:0] acc_cur [CH];
    logic signed [AW-1:0] acc_d   [CH];
    logic signed [AW-1:0] sx      [CH];
    logic [CH*DW-1:0]     win_data;

    logic accept, out_fire, mode_eff, member, first, complete, acc_we;
    logic c_last, r_last;

    assign s_ready = rdy_en_q && (!m_valid_q || m_ready);
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

    assign accept   = s_valid && s_ready;
    assign out_fire = m_valid_q && m_ready;
    // The first beat of a frame already uses the mode being latched.
    assign mode_eff = (state_q == IDLE) ? mode : mode_q;
    assign member   = (rp_q < PW'(KERNEL)) && (cp_q < PW'(KERNEL)) &&
                      (oh_q < RW'(OUT_H)) && (ow_q < CW'(OUT_W));
    assign first    = (rp_q == '0) && (cp_q == '0);
    assign complete = member && (rp_q == PW'(KERNEL-1)) && (cp_q == PW'(KERNEL-1));
    assign acc_we   = accept && member;
    assign c_last   = (c_q == CW'(IN_W-1));
    assign r_last   = (r_q == RW'(IN_H-1));

    // Datapath: fold the incoming sample into the current column's accumulator.
    always_comb begin
        win_data = '0;
        for (int ch = 0; ch < CH; ch++) begin
            acc_cur[ch] = '0;
            for (int i = 0; i < OUT_W; i++) begin
                if (ow_q == CW'(i)) begin
                    acc_cur[ch] = acc_q[i][ch];
                end
            end
            sx[ch] = {{(2*KL){s_data[ch*DW+DW-1]}}, s_data[ch*DW +: DW]};
            if (first) begin
                acc_d[ch] = sx[ch];
            end else if (mode_eff) begin
                acc_d[ch] = acc_cur[ch] + sx[ch];
            end else begin
                acc_d[ch] = (sx[ch] > acc_cur[ch]) ? sx[ch] : acc_cur[ch];
            end
            // acc >>> 2*KL truncated to DW is exactly the bit slice above 2*KL.
            win_data[ch*DW +: DW] = mode_eff ? acc_d[ch][2*KL +: DW] : acc_d[ch][DW-1:0];
        end
    end

    // Control: frame FSM, position counters and the output register.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        r_d       = r_q;
        c_d       = c_q;
        rp_d      = rp_q;
        cp_d      = cp_q;
        oh_d      = oh_q;
        ow_d      = ow_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;

        if (out_fire) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        if (accept) begin
            if (state_q == IDLE) begin
                mode_d  = mode;
                state_d = RUN;
            end
            // A completing beat overrides a drain on the same edge: no bubble.
            if (complete) begin
                m_valid_d = 1'b1;
                m_data_d  = win_data;
                m_last_d  = (oh_q == RW'(OUT_H-1)) && (ow_q == CW'(OUT_W-1));
            end
            if (c_last) begin
                c_d  = '0;
                cp_d = '0;
                ow_d = '0;
                if (r_last) begin
                    state_d = IDLE;
                    r_d     = '0;
                    rp_d    = '0;
                    oh_d    = '0;
                end else begin
                    r_d = r_q + 1'b1;
                    if (rp_q == PW'(STRIDE-1)) begin
                        rp_d = '0;
                        oh_d = oh_q + 1'b1;
                    end else begin
                        rp_d = rp_q + 1'b1;
                    end
                end
            end else begin
                c_d = c_q + 1'b1;
                if (cp_q == PW'(STRIDE-1)) begin
                    cp_d = '0;
                    ow_d = ow_q + 1'b1;
                end else begin
                    cp_d = cp_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            rdy_en_q  <= 1'b0;
            r_q       <= '0;
            c_q       <= '0;
            rp_q      <= '0;
            cp_q      <= '0;
            oh_q      <= '0;
            ow_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            rdy_en_q  <= 1'b1;
            r_q       <= r_d;
            c_q       <= c_d;
            rp_q      <= rp_d;
            cp_q      <= cp_d;
            oh_q      <= oh_d;
            ow_q      <= ow_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    // Accumulators are always seeded by a window's first beat, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < OUT_W; i++) begin
            if (acc_we && ow_q == CW'(i)) begin
                for (int ch = 0; ch < CH; ch++) begin
                    acc_q[i][ch] <= acc_d[ch];
                end
            end
        end
    end
endmodule

// File: tb/tb_pool2d_stream.sv
// Testbench for pool2d_stream: default instance (STRIDE=2) and a STRIDE=3
// instance, driven frame by frame and compared with a window-level model.
module tb_pool2d_stream;
    localparam int CH = 2, DW = 16, IN_H = 8, IN_W = 8, K = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             mode = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
    logic [CH*DW-1:0] s_data = '0;
    logic             s_ready, m_valid, m_last;
    logic [CH*DW-1:0] m_data;

    logic             mode3 = 1'b0, s_valid3 = 1'b0, m_ready3 = 1'b1;
    logic [CH*DW-1:0] s_data3 = '0;
    logic             s_ready3, m_valid3, m_last3;
    logic [CH*DW-1:0] m_data3;

    pool2d_stream dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    pool2d_stream #(.STRIDE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3),
        .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
        .m_valid(m_valid3), .m_ready(m_ready3), .m_data(m_data3), .m_last(m_last3)
    );

    int               pix [IN_H][IN_W][CH];
    logic [CH*DW:0]   exp_q [$];
    int               n_cmp = 0, n_bad = 0;
    int               out_cnt = 0, last_cnt = 0, stall_cnt = 0;
    logic             prev_cplt = 1'b0, prev_mr = 1'b0;
    int               bp_left = 0;
    bit               bp_arm = 1'b0, bp_resume = 1'b0;
    logic [CH*DW-1:0] held = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: pool every window straight from the stored frame.
    function automatic void build_exp(input bit avg, input int s);
        int oh_n = (IN_H - K) / s + 1;
        int ow_n = (IN_W - K) / s + 1;
        for (int oh = 0; oh < oh_n; oh++) begin
            for (int ow = 0; ow < ow_n; ow++) begin
                logic [CH*DW:0] w;
                w = '0;
                for (int ch = 0; ch < CH; ch++) begin
                    int sum, mx, val;
                    sum = 0;
                    mx = pix[oh*s][ow*s][ch];
                    for (int i = 0; i < K; i++) begin
                        for (int j = 0; j < K; j++) begin
                            sum += pix[oh*s+i][ow*s+j][ch];
                            if (pix[oh*s+i][ow*s+j][ch] > mx) mx = pix[oh*s+i][ow*s+j][ch];
                        end
                    end
                    // floor(sum / K^2), rounding toward minus infinity
                    if (sum >= 0) val = sum / (K*K);
                    else          val = -((-sum + K*K - 1) / (K*K));
                    w[ch*DW +: DW] = 16'(avg ? val : mx);
                end
                w[CH*DW] = (oh == oh_n - 1) && (ow == ow_n - 1);
                exp_q.push_back(w);
            end
        end
    endfunction

    function automatic void fill_ramp();
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++) begin
                pix[r][c][0] = r*8 + c;
                pix[r][c][1] = -(r*8 + c);
            end
    endfunction

    function automatic void fill_rand();
        logic [15:0] t;
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++)
                for (int ch = 0; ch < CH; ch++) begin
                    t = 16'($urandom);
                    pix[r][c][ch] = $signed(t);
                end
    endfunction

    task automatic drive(input int sel, input logic v, input logic [CH*DW-1:0] d, input logic mr);
        if (sel == 0) begin
            s_valid = v; s_data = d; m_ready = mr; s_valid3 = 1'b0; m_ready3 = 1'b1;
        end else begin
            s_valid3 = v; s_data3 = d; m_ready3 = mr; s_valid = 1'b0; m_ready = 1'b1;
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1 time unit later,
    // and account for the handshakes that the next rising edge will perform.
    task automatic cycle(input int sel, input logic v, input logic [CH*DW-1:0] d,
                         input logic cplt, output logic accd);
        logic sr, mv, ml, mr;
        logic [CH*DW-1:0] md;
        logic [CH*DW:0] e;
        @(negedge clk);
        mr = (bp_left > 0) ? 1'b0 : 1'b1;
        drive(sel, v, d, mr);
        #1;
        sr = (sel == 0) ? s_ready : s_ready3;
        mv = (sel == 0) ? m_valid : m_valid3;
        ml = (sel == 0) ? m_last  : m_last3;
        md = (sel == 0) ? m_data  : m_data3;
        if (bp_arm && mv) begin
            bp_arm = 1'b0; bp_left = 5; held = md; mr = 1'b0;
            drive(sel, v, d, mr);
            #1;
            sr = (sel == 0) ? s_ready : s_ready3;
        end
        if (prev_mr) chk("latency_mvalid", mv, prev_cplt);
        if (!mr) begin
            chk("bp_sready_low", sr, 1'b0);
            chk("bp_valid_hold", mv, 1'b1);
            chk("bp_data_hold", md, held);
            bp_left--;
            if (bp_left == 0) bp_resume = 1'b1;
        end else if (bp_resume) begin
            bp_resume = 1'b0;
            chk("bp_resume_sready", sr, 1'b1);
        end
        if (mr && !sr) stall_cnt++;
        if (mv && mr) begin
            out_cnt++;
            if (ml) last_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_output", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", md, e[CH*DW-1:0]);
                chk("out_last", ml, e[CH*DW]);
            end
        end
        accd = v && sr;
        prev_cplt = accd && cplt;
        prev_mr = mr;
    endtask

    task automatic do_reset(input bit abort);
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0; s_valid3 = 1'b0;
        #1;
        if (abort) begin
            chk("abort_mvalid", m_valid, 1'b0);
            chk("abort_sready", s_ready, 1'b0);
            chk("abort_outs_before", out_cnt, 4);
        end else begin
            chk("rst_mvalid", m_valid, 1'b0);
            chk("rst_mdata", m_data, '0);
            chk("rst_mlast", m_last, 1'b0);
            chk("rst_sready", s_ready, 1'b0);
            chk("rst_mvalid3", m_valid3, 1'b0);
        end
        exp_q.delete();
        out_cnt = 0; last_cnt = 0; prev_cplt = 1'b0; prev_mr = 1'b0;
        bp_left = 0; bp_arm = 1'b0; bp_resume = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_sready_low", s_ready, 1'b0);
        @(negedge clk);
        #1;
        chk("release_sready_high", s_ready, 1'b1);
    endtask

    task automatic send_frame(input int sel, input int s, input logic md_sel,
                              input int toggle_at, input int abort_at);
        int beats, tries, oh_n, ow_n;
        logic accd, cplt;
        logic [CH*DW-1:0] d;
        beats = 0;
        oh_n = (IN_H - K) / s + 1;
        ow_n = (IN_W - K) / s + 1;
        if (sel == 0) mode = md_sel; else mode3 = md_sel;
        for (int r = 0; r < IN_H; r++) begin
            for (int c = 0; c < IN_W; c++) begin
                d = '0;
                for (int ch = 0; ch < CH; ch++) d[ch*DW +: DW] = 16'(pix[r][c][ch]);
                cplt = (r % s == K-1) && (c % s == K-1) && (r / s < oh_n) && (c / s < ow_n);
                tries = 0;
                accd = 1'b0;
                while (!accd && tries < 50) begin
                    cycle(sel, 1'b1, d, cplt, accd);
                    tries++;
                end
                if (!accd) begin
                    chk("beat_accept_timeout", 1'b0, 1'b1);
                    return;
                end
                beats++;
                if (beats == toggle_at) mode = ~mode;
                if (beats == abort_at) begin
                    do_reset(1'b1);
                    return;
                end
            end
        end
    endtask

    task automatic drain(input int sel, input int n_exp, input int n_last);
        int t;
        logic accd;
        t = 0;
        while (exp_q.size() > 0 && t < 40) begin
            cycle(sel, 1'b0, '0, 1'b0, accd);
            t++;
        end
        repeat (2) cycle(sel, 1'b0, '0, 1'b0, accd);
        chk("drain_leftover", exp_q.size(), 0);
        chk("out_count", out_cnt, n_exp);
        chk("last_count", last_cnt, n_last);
        out_cnt = 0;
        last_cnt = 0;
    endtask

    initial begin
        do_reset(1'b0);

        // MAX on the ramp, sustained throughput
        fill_ramp();
        build_exp(1'b0, 2);
        stall_cnt = 0;
        send_frame(0, 2, 1'b0, -1, -1);
        drain(0, 16, 1);
        chk("ramp_no_stall", stall_cnt, 0);

        // AVG floor behaviour and full-scale sums
        fill_rand();
        pix[0][0][0] = -1; pix[0][1][0] = 0; pix[1][0][0] = 0; pix[1][1][0] = 0;
        pix[0][2][0] = 3;  pix[0][3][0] = 3; pix[1][2][0] = 3; pix[1][3][0] = 2;
        for (int i = 0; i < 2; i++)
            for (int j = 4; j < 6; j++) pix[i][j][0] = 32767;
        build_exp(1'b1, 2);
        send_frame(0, 2, 1'b1, -1, -1);
        drain(0, 16, 1);

        // random frames in both modes
        repeat (2) begin
            fill_rand();
            build_exp(1'b0, 2);
            send_frame(0, 2, 1'b0, -1, -1);
            drain(0, 16, 1);
            fill_rand();
            build_exp(1'b1, 2);
            send_frame(0, 2, 1'b1, -1, -1);
            drain(0, 16, 1);
        end

        // back-pressure after the first output
        fill_ramp();
        build_exp(1'b0, 2);
        bp_arm = 1'b1;
        send_frame(0, 2, 1'b0, -1, -1);
        drain(0, 16, 1);
        chk("bp_was_exercised", bp_arm, 1'b0);

        // STRIDE=3 instance: gap rows/columns discarded
        fill_ramp();
        build_exp(1'b0, 3);
        send_frame(1, 3, 1'b0, -1, -1);
        drain(1, 9, 1);

        // mode toggled mid-frame, then reset after 20 beats
        fill_rand();
        build_exp(1'b0, 2);
        send_frame(0, 2, 1'b0, 5, 20);
        fill_rand();
        build_exp(1'b0, 2);
        send_frame(0, 2, 1'b0, -1, -1);
        drain(0, 16, 1);

        // back-to-back frames, MAX then AVG, no idle cycle between
        fill_rand();
        build_exp(1'b0, 2);
        send_frame(0, 2, 1'b0, -1, -1);
        fill_rand();
        build_exp(1'b1, 2);
        send_frame(0, 2, 1'b1, -1, -1);
        drain(0, 32, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
